pooling_tile_scheduler: RTL and testbench
=========================================

// Module: pooling_tile_scheduler
// PURPOSE
//  Sequences the pooling controller across the output tiles of one conv layer.
//  - Accepts a per-layer pooling config.
//  - Arms the pooling controller once per tile the systolic array produces.
//  - Counts window completions and hands each finished tile to the writeback buffer (valid/ready).
//  - Flags bad configs and stalled tiles.
// PARAMETERS
//  COLS      4    width of replicated pooling enable vector pl_en_o
//  TILE_W    5    width of tile count / tile index
//  TIMEOUT   255  max cycles in RUN without pl_win_done before error (1..2^16-1)
// PORTS
//  clk               in   1       clock
//  rst_n             in   1       async active-low reset
//  cfg_valid         in   1       layer config offered
//  cfg_ready         out  1       config accepted when valid&ready
//  cfg_kernel_dim    in   3       pooling kernel dim, legal 1..4
//  cfg_stride        in   3       window stride, legal 1..7
//  cfg_win_per_tile  in   3       windows per tile, legal 1..7
//  cfg_num_tiles     in   TILE_W  tiles in layer, legal >=1
//  abort             in   1       cancel layer, highest priority
//  tile_ready_i      in   1       array has a tile staged for pooling
//  tile_ack_o        out  1       1-cycle pulse: tile consumed
//  pl_en_o           out  COLS    pooling enable, all bits equal
//  pl_start_o        out  1       1-cycle start (drives controller input_flag)
//  pl_reg_index_o    out  1       0 when kernel_dim==1, else 1
//  pl_kernel_dim_o   out  3       latched cfg_kernel_dim
//  pl_stride_o       out  3       latched cfg_stride
//  pl_win_o          out  3       latched cfg_win_per_tile
//  pl_win_done_i     in   1       pulse: one pooling window finished
//  wb_valid          out  1       finished tile available
//  wb_ready          in   1       writeback accepts
//  wb_tile_idx       out  TILE_W  index of finished tile, 0-based
//  busy              out  1       state != IDLE
//  layer_done        out  1       1-cycle pulse after last tile written back
//  err_cfg           out  1       1-cycle pulse: illegal config rejected
//  err_timeout       out  1       sticky until next accepted cfg
// BEHAVIOUR
//  Reset: state=IDLE, all outputs 0 except cfg_ready=1; latched cfg, counters, err_timeout cleared.
//  FSM IDLE -> WAIT_TILE -> RUN -> FLUSH -> (WAIT_TILE | DONE) -> IDLE.
//  IDLE: cfg_ready=1 (0 while abort=1). On handshake latch cfg, clear err_timeout.
//   - Legal cfg -> WAIT_TILE, tile_cnt=0, pl_en_o=all-1s from next cycle.
//   - Illegal cfg -> err_cfg pulse next cycle, stay IDLE, latched values unchanged.
//  WAIT_TILE: on tile_ready_i, in the same registered cycle pulse pl_start_o and tile_ack_o,
//   clear win_cnt and watchdog, -> RUN.
//  RUN: each pl_win_done_i increments win_cnt and reloads watchdog.
//   - Done with win_cnt==cfg_win_per_tile-1 -> FLUSH.
//   - Watchdog reaching TIMEOUT -> set err_timeout, drop pl_en_o, -> IDLE.
//  FLUSH: wb_valid=1, wb_tile_idx=tile_cnt, both held stable until wb_ready.
//   - On wb_valid&wb_ready: if tile_cnt==cfg_num_tiles-1 -> DONE, else tile_cnt++ -> WAIT_TILE.
//  DONE: layer_done=1 for exactly one cycle, pl_en_o=0, -> IDLE.
//  pl_win_done_i outside RUN is ignored (no count, no error).
//  abort: any state -> IDLE next cycle; pl_en_o, wb_valid, pl_start_o cleared;
//   no layer_done, err_timeout unchanged.
//  Latency: tile_ready_i high in WAIT_TILE -> pl_start_o 1 cycle later;
//   last pl_win_done_i -> wb_valid 1 cycle later.
//  Widths: win_cnt 3b, tile_cnt TILE_W; watchdog 16b, saturates.
//  Async reset mid-layer returns to reset values immediately; no partial tile reported.
// TESTING
//  1 Reset: hold rst_n=0 -> cfg_ready=1, every other output 0.
//  2 cfg(k=2,s=2,w=3,tiles=2), tile_ready each time, 3 win_done per tile, wb_ready=1:
//    wb_tile_idx 0 then 1; layer_done one pulse; pl_reg_index_o=1.
//  3 k=1,w=1,tiles=1 with wb_ready held 0 for 5 cycles: wb_valid/idx stable 5 cycles,
//    layer_done 2 cycles after wb_ready rises; pl_reg_index_o=0.
//  4 cfg k=0, then tiles=0: err_cfg pulses, busy stays 0, next legal cfg accepted.
//  5 TIMEOUT=8, no win_done in RUN: err_timeout set at 8 cycles, state IDLE;
//    next cfg clears it.
//  6 abort in RUN with pl_win_done_i same cycle: IDLE next cycle, pl_en_o=0,
//    no wb_valid, no layer_done.

Source files
------------

// File: rtl/pooling_tile_scheduler.sv
// Pooling tile scheduler: walks the pooling controller through every output
// tile of one conv layer, counts completed windows per tile, and hands each
// finished tile index to the writeback buffer over a valid/ready handshake.
module pooling_tile_scheduler #(
  parameter int COLS    = 4,
  parameter int TILE_W  = 5,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [2:0]        cfg_kernel_dim,
  input  logic [2:0]        cfg_stride,
  input  logic [2:0]        cfg_win_per_tile,
  input  logic [TILE_W-1:0] cfg_num_tiles,
  input  logic              abort,
  input  logic              tile_ready_i,
  output logic              tile_ack_o,
  output logic [COLS-1:0]   pl_en_o,
  output logic              pl_start_o,
  output logic              pl_reg_index_o,
  output logic [2:0]        pl_kernel_dim_o,
  output logic [2:0]        pl_stride_o,
  output logic [2:0]        pl_win_o,
  input  logic              pl_win_done_i,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [TILE_W-1:0] wb_tile_idx,
  output logic              busy,
  output logic              layer_done,
  output logic              err_cfg,
  output logic              err_timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_TILE,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_t;

  localparam logic [15:0] TIMEOUT_L = 16'(TIMEOUT);

  state_t            state_q, state_d;
  logic [2:0]        kdim_q, stride_q, win_q;
  logic [TILE_W-1:0] tiles_q, tile_cnt_q;
  logic [2:0]        win_cnt_q;
  logic [15:0]       wd_q, wd_inc;
  logic              start_q, err_cfg_q, err_to_q;
  logic              cfg_hs, cfg_ok, wd_expire, last_win, last_tile, wb_hs, en;

  // A layer config is usable only if every field is inside its legal range.
  function automatic logic cfg_legal(input logic [2:0] k, input logic [2:0] s,
                                     input logic [2:0] w, input logic [TILE_W-1:0] n);
    return (k >= 3'd1) && (k <= 3'd4) && (s != 3'd0) && (w != 3'd0) && (n != '0);
  endfunction

  // Watchdog increment that sticks at full scale instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Next-state decode; abort overrides every other transition.
  always_comb begin
    cfg_hs    = cfg_valid && cfg_ready;
    cfg_ok    = cfg_legal(cfg_kernel_dim, cfg_stride, cfg_win_per_tile, cfg_num_tiles);
    wd_inc    = sat_inc16(wd_q);
    wd_expire = (state_q == S_RUN) && !pl_win_done_i && (wd_inc >= TIMEOUT_L);
    last_win  = pl_win_done_i && (win_cnt_q == win_q - 3'd1);
    wb_hs     = (state_q == S_FLUSH) && wb_ready;
    last_tile = (tile_cnt_q == tiles_q - TILE_W'(1));
    state_d   = state_q;
    case (state_q)
      S_IDLE:      if (cfg_hs && cfg_ok) state_d = S_WAIT_TILE;
      S_WAIT_TILE: if (tile_ready_i) state_d = S_RUN;
      S_RUN: begin
        if (last_win)       state_d = S_FLUSH;
        else if (wd_expire) state_d = S_IDLE;
      end
      S_FLUSH:     if (wb_ready) state_d = last_tile ? S_DONE : S_WAIT_TILE;
      S_DONE:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Latched config, tile/window counters, watchdog and registered status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kdim_q     <= '0;
      stride_q   <= '0;
      win_q      <= '0;
      tiles_q    <= '0;
      tile_cnt_q <= '0;
      win_cnt_q  <= '0;
      wd_q       <= '0;
      start_q    <= 1'b0;
      err_cfg_q  <= 1'b0;
      err_to_q   <= 1'b0;
    end else begin
      start_q   <= (state_q == S_WAIT_TILE) && tile_ready_i && !abort;
      err_cfg_q <= cfg_hs && !cfg_ok;
      if (cfg_hs)                   err_to_q <= 1'b0;
      else if (wd_expire && !abort) err_to_q <= 1'b1;
      if (cfg_hs && cfg_ok) begin
        kdim_q     <= cfg_kernel_dim;
        stride_q   <= cfg_stride;
        win_q      <= cfg_win_per_tile;
        tiles_q    <= cfg_num_tiles;
        tile_cnt_q <= '0;
      end
      if ((state_q == S_WAIT_TILE) && tile_ready_i) begin
        win_cnt_q <= '0;
        wd_q      <= '0;
      end
      if (state_q == S_RUN) begin
        if (pl_win_done_i) begin
          win_cnt_q <= win_cnt_q + 3'd1;
          wd_q      <= '0;
        end else begin
          wd_q <= wd_inc;
        end
      end
      if (wb_hs && !last_tile) tile_cnt_q <= tile_cnt_q + TILE_W'(1);
    end
  end

  assign en              = (state_q == S_WAIT_TILE) || (state_q == S_RUN) || (state_q == S_FLUSH);
  assign cfg_ready       = (state_q == S_IDLE) && !abort;
  assign tile_ack_o      = start_q;
  assign pl_start_o      = start_q;
  assign pl_en_o         = {COLS{en}};
  assign pl_reg_index_o  = (kdim_q > 3'd1);
  assign pl_kernel_dim_o = kdim_q;
  assign pl_stride_o     = stride_q;
  assign pl_win_o        = win_q;
  assign wb_valid        = (state_q == S_FLUSH);
  assign wb_tile_idx     = wb_valid ? tile_cnt_q : '0;
  assign busy            = (state_q != S_IDLE);
  assign layer_done      = (state_q == S_DONE);
  assign err_cfg         = err_cfg_q;
  assign err_timeout     = err_to_q;

endmodule

// File: tb/tb_pooling_tile_scheduler.sv
// Bench for pooling_tile_scheduler: directed scenarios plus randomized layers,
// with a scoreboard of expected writeback tile indices and layer completions.
module tb_pooling_tile_scheduler;
  localparam int COLS    = 4;
  localparam int TILE_W  = 5;
  localparam int TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [2:0]        cfg_kernel_dim = '0, cfg_stride = '0, cfg_win_per_tile = '0;
  logic [TILE_W-1:0] cfg_num_tiles = '0;
  logic              abort = 1'b0, tile_ready_i = 1'b0, pl_win_done_i = 1'b0;
  logic              wb_ready;
  logic              tile_ack_o, pl_start_o, pl_reg_index_o, wb_valid;
  logic [COLS-1:0]   pl_en_o;
  logic [2:0]        pl_kernel_dim_o, pl_stride_o, pl_win_o;
  logic [TILE_W-1:0] wb_tile_idx;
  logic              busy, layer_done, err_cfg, err_timeout;

  int n_cmp = 0, n_bad = 0;
  int exp_idx_q[$];
  int exp_done_q[$];
  bit wb_mode = 1'b0;
  logic wb_force = 1'b0;
  bit mon_en = 1'b0;
  int lk = 0, ls = 0, lw = 0;

  pooling_tile_scheduler #(.COLS(COLS), .TILE_W(TILE_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_kernel_dim(cfg_kernel_dim), .cfg_stride(cfg_stride),
    .cfg_win_per_tile(cfg_win_per_tile), .cfg_num_tiles(cfg_num_tiles),
    .abort(abort), .tile_ready_i(tile_ready_i), .tile_ack_o(tile_ack_o),
    .pl_en_o(pl_en_o), .pl_start_o(pl_start_o), .pl_reg_index_o(pl_reg_index_o),
    .pl_kernel_dim_o(pl_kernel_dim_o), .pl_stride_o(pl_stride_o), .pl_win_o(pl_win_o),
    .pl_win_done_i(pl_win_done_i), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_tile_idx(wb_tile_idx), .busy(busy), .layer_done(layer_done),
    .err_cfg(err_cfg), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event seen, none expected", name);
  endtask

  function automatic bit legal(input int k, input int s, input int w, input int n);
    return (k >= 1) && (k <= 4) && (s >= 1) && (s <= 7) && (w >= 1) && (w <= 7) && (n >= 1);
  endfunction

  // writeback ready source: random or forced level, applied 2 time units after the edge
  initial begin
    wb_ready = 1'b0;
    forever begin
      @(posedge clk); #2;
      wb_ready = wb_mode ? 1'($urandom_range(0, 1)) : wb_force;
    end
  end

  // monitor: pops the scoreboard on every handshake / layer_done and checks hold stability
  initial begin
    logic stall_prev;
    logic [TILE_W-1:0] idx_prev;
    stall_prev = 1'b0;
    idx_prev = '0;
    forever begin
      @(negedge clk);
      if (!rst_n || !mon_en) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check("wb_hold_valid", wb_valid, 1);
          check("wb_hold_idx", wb_tile_idx, idx_prev);
        end
        if (wb_valid && wb_ready) begin
          if (exp_idx_q.size() == 0) flag("wb_unexpected");
          else check("wb_tile_idx", wb_tile_idx, exp_idx_q.pop_front());
        end
        if (layer_done) begin
          if (exp_done_q.size() == 0) flag("layer_done_unexpected");
          else void'(exp_done_q.pop_front());
        end
        stall_prev = wb_valid && !wb_ready && !abort;
        idx_prev = wb_tile_idx;
      end
    end
  end

  // Offers one config starting at a negedge; returns whether it should be accepted.
  task automatic send_cfg(input int k, input int s, input int w, input int n, output bit ok);
    ok = legal(k, s, w, n);
    cfg_kernel_dim = 3'(k);
    cfg_stride = 3'(s);
    cfg_win_per_tile = 3'(w);
    cfg_num_tiles = TILE_W'(n);
    cfg_valid = 1'b1;
    check("cfg_ready_idle", cfg_ready, 1);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    @(negedge clk);
    check("err_cfg_pulse", err_cfg, !ok);
    check("busy_after_cfg", busy, ok);
    if (ok) begin
      lk = k; ls = s; lw = w;
      check("pl_en_on", pl_en_o, (1 << COLS) - 1);
      check("err_timeout_cleared", err_timeout, 0);
    end else begin
      @(negedge clk);
      check("err_cfg_one_cycle", err_cfg, 0);
      check("busy_stays_0", busy, 0);
    end
    check("pl_kernel_dim", pl_kernel_dim_o, lk);
    check("pl_stride", pl_stride_o, ls);
    check("pl_win", pl_win_o, lw);
    check("pl_reg_index", pl_reg_index_o, (lk > 1));
  endtask

  // Presents a tile (optionally after a stray win_done while waiting) and waits for its ack.
  task automatic start_tile();
    bit got;
    if ($urandom_range(0, 2) == 0) begin
      @(posedge clk); #1; pl_win_done_i = 1'b1;
      @(posedge clk); #1; pl_win_done_i = 1'b0;
    end
    repeat ($urandom_range(0, 2)) @(posedge clk);
    @(posedge clk); #1;
    tile_ready_i = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (tile_ack_o) got = 1'b1;
    end
    tile_ready_i = 1'b0;
    check("tile_ack_seen", got, 1);
    check("pl_start_with_ack", pl_start_o, 1);
  endtask

  task automatic run_windows(input int w);
    @(posedge clk); #1;
    check("tile_ack_one_cycle", tile_ack_o, 0);
    check("pl_start_one_cycle", pl_start_o, 0);
    for (int i = 0; i < w; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      @(posedge clk); #1; pl_win_done_i = 1'b1;
      @(posedge clk); #1; pl_win_done_i = 1'b0;
    end
    check("wb_valid_after_last_win", wb_valid, 1);
  endtask

  task automatic wait_wb();
    bit got;
    got = 1'b0;
    for (int c = 0; c < 60 && !got; c++) begin
      @(negedge clk);
      if (wb_valid && wb_ready) got = 1'b1;
    end
    check("wb_handshake_seen", got, 1);
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int c = 0; c < 10 && !idle; c++) begin
      @(negedge clk);
      if (!busy) idle = 1'b1;
    end
    check("returned_idle", idle, 1);
  endtask

  task automatic run_layer(input int k, input int s, input int w, input int n);
    bit ok;
    send_cfg(k, s, w, n, ok);
    if (ok) begin
      for (int t = 0; t < n; t++) exp_idx_q.push_back(t);
      exp_done_q.push_back(1);
      for (int t = 0; t < n; t++) begin
        start_tile();
        run_windows(w);
        wait_wb();
      end
      wait_idle();
      check("idx_queue_drained", exp_idx_q.size(), 0);
      check("done_queue_drained", exp_done_q.size(), 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit: bench did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    bit ok;
    // reset state
    repeat (3) @(negedge clk);
    check("rst_cfg_ready", cfg_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_pl_en", pl_en_o, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_wb_idx", wb_tile_idx, 0);
    check("rst_tile_ack", tile_ack_o, 0);
    check("rst_pl_start", pl_start_o, 0);
    check("rst_reg_index", pl_reg_index_o, 0);
    check("rst_kernel", pl_kernel_dim_o, 0);
    check("rst_stride", pl_stride_o, 0);
    check("rst_win", pl_win_o, 0);
    check("rst_layer_done", layer_done, 0);
    check("rst_err_cfg", err_cfg, 0);
    check("rst_err_timeout", err_timeout, 0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    // two-tile layer, writeback always ready
    wb_mode = 1'b0; wb_force = 1'b1;
    run_layer(2, 2, 3, 2);

    // single tile with writeback stalled five cycles
    wb_force = 1'b0;
    @(negedge clk);
    send_cfg(1, 3, 1, 1, ok);
    exp_idx_q.push_back(0);
    exp_done_q.push_back(1);
    start_tile();
    run_windows(1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_wb_valid", wb_valid, 1);
      check("stall_wb_idx", wb_tile_idx, 0);
    end
    @(posedge clk); #1; wb_force = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("stall_layer_done_on", layer_done, 1);
    @(negedge clk);
    check("stall_layer_done_off", layer_done, 0);
    check("stall_idle", busy, 0);

    // illegal configs followed by a legal one
    send_cfg(0, 2, 2, 1, ok);
    send_cfg(2, 2, 2, 0, ok);
    send_cfg(5, 1, 1, 1, ok);
    run_layer(3, 1, 2, 2);

    // watchdog expiry with no window completions
    send_cfg(2, 1, 2, 1, ok);
    start_tile();
    repeat (7) @(negedge clk);
    check("to_not_yet", err_timeout, 0);
    check("to_busy_before", busy, 1);
    @(negedge clk);
    check("to_set", err_timeout, 1);
    check("to_idle", busy, 0);
    check("to_pl_en_off", pl_en_o, 0);
    repeat (3) @(negedge clk);
    check("to_sticky", err_timeout, 1);
    run_layer(1, 1, 1, 1);

    // abort in RUN coinciding with a window completion
    send_cfg(2, 2, 2, 1, ok);
    start_tile();
    @(posedge clk); #1; abort = 1'b1; pl_win_done_i = 1'b1;
    @(negedge clk);
    check("abort_busy_still", busy, 1);
    @(posedge clk); #1; abort = 1'b0; pl_win_done_i = 1'b0;
    @(negedge clk);
    check("abort_idle", busy, 0);
    check("abort_pl_en", pl_en_o, 0);
    check("abort_wb_valid", wb_valid, 0);
    check("abort_layer_done", layer_done, 0);
    check("abort_err_timeout", err_timeout, 0);
    repeat (4) begin
      @(negedge clk);
      check("abort_no_wb", wb_valid, 0);
    end
    abort = 1'b1;
    #1 check("abort_blocks_cfg_ready", cfg_ready, 0);
    abort = 1'b0;
    #1 check("cfg_ready_back", cfg_ready, 1);
    @(negedge clk);

    // randomized layers, including occasional illegal configs
    wb_mode = 1'b1;
    repeat (10) begin
      run_layer($urandom_range(0, 5), $urandom_range(0, 7), $urandom_range(0, 7),
                $urandom_range(0, 4));
      @(negedge clk);
    end

    // asynchronous reset in the middle of a tile
    wb_mode = 1'b0; wb_force = 1'b1;
    send_cfg(3, 2, 4, 2, ok);
    start_tile();
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_pl_en", pl_en_o, 0);
    check("arst_cfg_ready", cfg_ready, 1);
    check("arst_kernel", pl_kernel_dim_o, 0);
    check("arst_wb_valid", wb_valid, 0);
    lk = 0; ls = 0; lw = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_layer(4, 7, 2, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
